debug_snapshot_monitor: RTL and testbench
=========================================

# debug_snapshot_monitor

Synthesizable successor to the processor's simulation-only debug monitor. It watches commit, mispredict and dump-request events. On each accepted event it walks a parametrised list of architectural registers through the rename map and the physical register file, then streams the captured values out over a valid/ready port. It also keeps a mispredict counter, a dropped-event counter and an optional commit watchdog. It sits beside `processor`, tapping the rename map and PRF read ports, with no effect on architectural state.

## Interface
- `NUM_WATCH`, 4: number of watched architectural registers (1–32).
- `AREG_W`, 5: architectural register index width.
- `PREG_W`, 7: physical register index width.
- `DATA_W`, 32: register data width.
- `CNT_W`, 16: width of the mispredict and drop counters (saturating).
- `TIMEOUT`, 2000: watchdog limit in cycles without a commit (≥2).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `commit_valid` in 1: at least one ROB commit this cycle.
- `mispredict` in 1: branch mispredict pulse.
- `dump_req` in 1: external snapshot request pulse.
- `hang_clr` in 1: clears the sticky hang flag.
- `watch_sel` in NUM_WATCH*AREG_W: architectural index per slot; slot 0 occupies the LSBs; static during a walk.
- `map_raddr` out AREG_W: rename-map read address.
- `map_rdata` in PREG_W: combinational map result.
- `prf_raddr` out PREG_W: PRF read address.
- `prf_rdata` in DATA_W: combinational PRF result.
- `out_valid` out 1, `out_ready` in 1: snapshot stream handshake.
- `out_cause` out 2: trigger cause, 0 = mispredict, 1 = hang, 2 = dump.
- `out_slot` out $clog2(NUM_WATCH) (min 1): slot index.
- `out_preg` out PREG_W, `out_data` out DATA_W: captured mapping and value.
- `out_seq` out CNT_W: mispredict count latched at trigger.
- `out_last` out 1: high on the final slot of a walk.
- `busy` out 1: FSM not IDLE.
- `hang` out 1: sticky watchdog flag.
- `mispredict_count`, `drop_count` out CNT_W.

## Operation
- FSM states: IDLE, MAP, RD, OUT.
- **IDLE.** An accepted trigger latches the cause and `out_seq`, sets slot to 0 and moves to MAP.
- **MAP.** Drives `map_raddr = watch_sel[slot]` and captures `map_rdata` into the preg register. Next state is RD.
- **RD.** Drives `prf_raddr` = captured preg and captures `prf_rdata`. Next state is OUT.
- **OUT.** `out_valid` = 1. On `out_valid && out_ready`:
  - if this was slot NUM_WATCH-1, go to IDLE;
  - otherwise increment the slot and go to MAP.
- Outputs stay stable while `out_valid && !out_ready`.
- Trigger priority, when events coincide in IDLE: dump > hang rising edge > mispredict. Lower-priority events arriving in the same cycle count as dropped.
- Any trigger arriving while `busy` is dropped, and `drop_count` increments by 1 per cycle with a dropped event.
- `mispredict_count` increments on every `mispredict` pulse, whether idle or busy.
- `out_seq` is the count value including the triggering mispredict.
- Both counters saturate at 2^CNT_W−1.
- `map_raddr` and `prf_raddr` are 0 outside MAP and RD respectively.

## Timing
- Reset values: FSM = IDLE, all outputs 0, counters 0, watchdog 0, `hang` = 0.
- Asserting reset mid-walk aborts the walk immediately; no partial beat remains.
- Trigger sampled at edge N gives MAP in cycle N+1, RD in N+2, and `out_valid` from N+3.
- Each slot takes a minimum of 3 cycles, so a full walk is at least 3·NUM_WATCH cycles with `out_ready` held high.
- A new trigger is accepted in the same cycle the last beat is accepted only if the FSM is in IDLE. It is not, so that trigger is dropped; the first acceptable cycle is the one after.
- Watchdog:
  - the counter clears on `commit_valid` and increments otherwise;
  - `hang` rises on the edge at which the counter reaches TIMEOUT;
  - the counter then holds;
  - `hang` clears only on `hang_clr` or reset;
  - a hang trigger fires once, on the rising edge of `hang`;
  - `hang_clr` and a timeout in the same cycle leave `hang` = 1.

## Configuration
- `DBG_SNAPSHOT_WATCHDOG_EN` defined: the watchdog counter, the `hang` flag and cause 1 are present.
- Not defined: no watchdog logic is built, `hang` is tied to 0 and `hang_clr` is ignored; cause 1 never appears.

## Test plan
- NUM_WATCH=4, `watch_sel` = {28,7,11,10}, map 10→40, 11→41, 7→17, 28→58, PRF[40]=0x5, single `mispredict` pulse, `out_ready` = 1 → 4 beats with slots 0..3, slot 0 carrying preg 40 and data 0x5, cause 0, `out_seq` = 1, `out_last` on slot 3, `out_valid` first in cycle N+3.
- `out_ready` held low for 5 cycles in OUT → outputs stable, no extra beats, walk resumes when `out_ready` rises.
- Three `mispredict` pulses during a walk → `mispredict_count` = 4, `drop_count` = 3, no extra walk starts.
- `dump_req` and `mispredict` in the same IDLE cycle → walk cause 2, `drop_count` = 1, `mispredict_count` = 1.
- TIMEOUT=16, no commits (macro defined) → `hang` rises exactly 16 cycles after the last commit, one walk with cause 1 starts, `hang_clr` drops `hang` to 0; a `commit_valid` before the 16th cycle leaves `hang` at 0.
- Reset asserted mid-OUT → all outputs 0 asynchronously, state IDLE, counters 0.

Source files
------------

// File: rtl/debug_snapshot_monitor.sv
// debug_snapshot_monitor: snapshots watched architectural registers on commit-side debug events
// and streams them out over a valid/ready port.
// Events: mispredict, dump_req, and the watchdog hang rising edge (cause 0/2/1).
// Ports: clk, reset (async, active-low); event inputs commit_valid/mispredict/dump_req/hang_clr;
// watch_sel packed slot list (slot 0 in the LSBs); map_raddr/map_rdata and prf_raddr/prf_rdata taps;
// out_* snapshot stream; busy, hang, mispredict_count, drop_count status.
// Optional feature: define DBG_SNAPSHOT_WATCHDOG_EN to build the commit watchdog and hang cause.
module debug_snapshot_monitor #(
  parameter int NUM_WATCH = 4,
  parameter int AREG_W    = 5,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 2000,
  localparam int SLOT_W   = NUM_WATCH > 1 ? $clog2(NUM_WATCH) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        commit_valid,
  input  logic                        mispredict,
  input  logic                        dump_req,
  input  logic                        hang_clr,
  input  logic [NUM_WATCH*AREG_W-1:0] watch_sel,
  output logic [AREG_W-1:0]           map_raddr,
  input  logic [PREG_W-1:0]           map_rdata,
  output logic [PREG_W-1:0]           prf_raddr,
  input  logic [DATA_W-1:0]           prf_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  out_cause,
  output logic [SLOT_W-1:0]           out_slot,
  output logic [PREG_W-1:0]           out_preg,
  output logic [DATA_W-1:0]           out_data,
  output logic [CNT_W-1:0]            out_seq,
  output logic                        out_last,
  output logic                        busy,
  output logic                        hang,
  output logic [CNT_W-1:0]            mispredict_count,
  output logic [CNT_W-1:0]            drop_count
);
  typedef enum logic [1:0] {IDLE, MAP, RD, OUT} state_t;
  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PREG_W-1:0]   preg_q, preg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    seq_q, seq_d, mcnt_q, mcnt_d, dcnt_q, dcnt_d;
  logic                hang_ev, last, drop;
`ifdef DBG_SNAPSHOT_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            hang_q, hang_d, hang_set;
  // hang_set marks the cycle whose edge brings the counter to TIMEOUT
  assign hang_set = !commit_valid && wd_q == WD_W'(TIMEOUT - 1);
  assign wd_d     = commit_valid ? '0 : wd_q == WD_W'(TIMEOUT) ? wd_q : wd_q + 1'b1;
  assign hang_d   = hang_set | (hang_q & !hang_clr);
  assign hang_ev  = hang_set & !hang_q;
  assign hang     = hang_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wd_q   <= '0;
      hang_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      hang_q <= hang_d;
    end
`else
  localparam int unused_timeout = TIMEOUT;
  logic unused_ok;
  assign unused_ok = &{1'b0, hang_clr, commit_valid};
  assign hang_ev   = 1'b0;
  assign hang      = 1'b0;
`endif
  assign busy             = state_q != IDLE;
  assign last             = slot_q == SLOT_W'(NUM_WATCH - 1);
  assign out_valid        = state_q == OUT;
  assign out_last         = out_valid & last;
  assign out_slot         = slot_q;
  assign out_preg         = preg_q;
  assign out_data         = data_q;
  assign out_cause        = cause_q;
  assign out_seq          = seq_q;
  assign mispredict_count = mcnt_q;
  assign drop_count       = dcnt_q;
  assign map_raddr        = state_q == MAP ? watch_sel[int'(slot_q)*AREG_W +: AREG_W] : '0;
  assign prf_raddr        = state_q == RD ? preg_q : '0;
  // while busy every event is dropped; in IDLE only the losers of the priority pick are
  assign drop = busy ? (dump_req | hang_ev | mispredict)
                     : (dump_req & (hang_ev | mispredict)) | (hang_ev & mispredict);
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    preg_d  = preg_q;
    data_d  = data_q;
    cause_d = cause_q;
    seq_d   = seq_q;
    mcnt_d  = (mispredict && !(&mcnt_q)) ? mcnt_q + 1'b1 : mcnt_q;
    dcnt_d  = (drop && !(&dcnt_q)) ? dcnt_q + 1'b1 : dcnt_q;
    case (state_q)
      IDLE: if (dump_req | hang_ev | mispredict) begin
        state_d = MAP;
        slot_d  = '0;
        cause_d = dump_req ? 2'd2 : hang_ev ? 2'd1 : 2'd0;
        seq_d   = mcnt_d;
      end
      MAP: begin
        preg_d  = map_rdata;
        state_d = RD;
      end
      RD: begin
        data_d  = prf_rdata;
        state_d = OUT;
      end
      OUT: if (out_ready) begin
        state_d = last ? IDLE : MAP;
        slot_d  = last ? slot_q : slot_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      preg_q  <= '0;
      data_q  <= '0;
      cause_q <= '0;
      seq_q   <= '0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      preg_q  <= preg_d;
      data_q  <= data_d;
      cause_q <= cause_d;
      seq_q   <= seq_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
    end
endmodule

// File: tb/tb_debug_snapshot_monitor.sv
// tb_debug_snapshot_monitor: directed bench for debug_snapshot_monitor
module tb_debug_snapshot_monitor;
  logic        clk = 0, reset = 0, commit_valid = 1, mispredict = 0, dump_req = 0, hang_clr = 0, out_ready = 1;
  logic [19:0] watch_sel = {5'd28, 5'd7, 5'd11, 5'd10};
  logic [4:0]  map_raddr;
  logic [6:0]  map_rdata, prf_raddr, out_preg;
  logic [31:0] prf_rdata, out_data;
  logic        out_valid, out_last, busy, hang;
  logic [1:0]  out_cause, out_slot;
  logic [2:0]  out_seq, mispredict_count, drop_count;
  int          passed = 0, total = 0;
  logic [6:0]  exp_preg [4] = '{7'd40, 7'd41, 7'd17, 7'd58};
  logic [31:0] exp_data [4] = '{32'h5, 32'hA000_0029, 32'hA000_0011, 32'hA000_003A};
  debug_snapshot_monitor #(.NUM_WATCH(4), .AREG_W(5), .PREG_W(7), .DATA_W(32), .CNT_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .mispredict(mispredict), .dump_req(dump_req),
    .hang_clr(hang_clr), .watch_sel(watch_sel), .map_raddr(map_raddr), .map_rdata(map_rdata),
    .prf_raddr(prf_raddr), .prf_rdata(prf_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_cause(out_cause), .out_slot(out_slot), .out_preg(out_preg), .out_data(out_data),
    .out_seq(out_seq), .out_last(out_last), .busy(busy), .hang(hang),
    .mispredict_count(mispredict_count), .drop_count(drop_count));
  always #5 clk = ~clk;
  always_comb begin
    map_rdata = 7'd0;
    case (map_raddr)
      5'd10: map_rdata = 7'd40;
      5'd11: map_rdata = 7'd41;
      5'd7:  map_rdata = 7'd17;
      5'd28: map_rdata = 7'd58;
      default: map_rdata = 7'd0;
    endcase
  end
  assign prf_rdata = prf_raddr == 7'd40 ? 32'h5 : 32'hA000_0000 | {25'd0, prf_raddr};
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick;
    check("idle_wait", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_mcnt", mispredict_count, 0);
    check("rst_dcnt", drop_count, 0);
    check("rst_hang", hang, 0);
    check("rst_map", map_raddr, 0);
    check("rst_prf", prf_raddr, 0);
    tick;
    reset = 1;
    tick;
    tick;
    // basic mispredict walk
    mispredict = 1;
    tick;
    mispredict = 0;
    check("t1_busy", busy, 1);
    check("t1_map0", map_raddr, 10);
    check("t1_nv_map", out_valid, 0);
    tick;
    check("t1_prf0", prf_raddr, 40);
    check("t1_map_off", map_raddr, 0);
    check("t1_nv_rd", out_valid, 0);
    tick;
    check("t1_prf_off", prf_raddr, 0);
    check("t1_cause", out_cause, 0);
    check("t1_seq", out_seq, 1);
    for (int s = 0; s < 4; s++) begin
      if (s > 0) begin
        tick;
        tick;
        tick;
      end
      check("t1_valid", out_valid, 1);
      check("t1_slot", out_slot, s);
      check("t1_preg", out_preg, exp_preg[s]);
      check("t1_data", out_data, exp_data[s]);
      check("t1_last", out_last, s == 3);
    end
    tick;
    check("t1_done", busy, 0);
    check("t1_done_v", out_valid, 0);
    // dump walk stalled 5 cycles with three mispredicts dropped
    out_ready = 0;
    dump_req = 1;
    tick;
    dump_req = 0;
    tick;
    tick;
    check("t2_valid", out_valid, 1);
    check("t2_cause", out_cause, 2);
    check("t2_seq", out_seq, 1);
    for (int k = 0; k < 5; k++) begin
      mispredict = k < 3;
      tick;
      check("t2_hold_v", out_valid, 1);
      check("t2_hold_s", out_slot, 0);
      check("t2_hold_p", out_preg, 40);
      check("t2_hold_d", out_data, 5);
    end
    mispredict = 0;
    check("t3_mcnt", mispredict_count, 4);
    check("t3_dcnt", drop_count, 3);
    out_ready = 1;
    tick;
    check("t2_resume_nv", out_valid, 0);
    tick;
    tick;
    check("t2_slot1", out_slot, 1);
    check("t2_data1", out_data, 32'hA000_0029);
    wait_idle(20);
    tick;
    check("t3_no_walk", busy, 0);
    check("t3_mcnt2", mispredict_count, 4);
    // asynchronous reset mid-OUT
    out_ready = 0;
    mispredict = 1;
    tick;
    mispredict = 0;
    tick;
    tick;
    check("t6_pre_v", out_valid, 1);
    #2;
    reset = 0;
    #1;
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_mcnt", mispredict_count, 0);
    check("t6_dcnt", drop_count, 0);
    check("t6_data", out_data, 0);
    check("t6_preg", out_preg, 0);
    check("t6_seq", out_seq, 0);
    reset = 1;
    tick;
    check("t6_stay", busy, 0);
    // dump and mispredict together in IDLE
    out_ready = 1;
    dump_req = 1;
    mispredict = 1;
    tick;
    dump_req = 0;
    mispredict = 0;
    check("t4_dcnt", drop_count, 1);
    check("t4_mcnt", mispredict_count, 1);
    tick;
    tick;
    check("t4_cause", out_cause, 2);
    check("t4_seq", out_seq, 1);
    for (int i = 0; i < 9; i++) tick;
    check("t4_last", out_last, 1);
    check("t4_slot3", out_slot, 3);
    // trigger during the last accepted beat is dropped
    mispredict = 1;
    tick;
    mispredict = 0;
    check("t5_idle", busy, 0);
    check("t5_dcnt", drop_count, 2);
    check("t5_mcnt", mispredict_count, 2);
    tick;
    check("t5_no_walk", busy, 0);
    // counter saturation
    out_ready = 0;
    dump_req = 1;
    tick;
    dump_req = 0;
    mispredict = 1;
    for (int i = 0; i < 8; i++) tick;
    mispredict = 0;
    check("sat_mcnt", mispredict_count, 7);
    check("sat_dcnt", drop_count, 7);
    out_ready = 1;
    wait_idle(30);
`ifdef DBG_SNAPSHOT_WATCHDOG_EN
    commit_valid = 1;
    tick;
    commit_valid = 0;
    for (int i = 0; i < 15; i++) tick;
    check("wd_pre", hang, 0);
    check("wd_pre_busy", busy, 0);
    tick;
    check("wd_hang", hang, 1);
    check("wd_busy", busy, 1);
    tick;
    tick;
    check("wd_cause", out_cause, 1);
    check("wd_valid", out_valid, 1);
    wait_idle(30);
    tick;
    check("wd_once", busy, 0);
    check("wd_sticky", hang, 1);
    hang_clr = 1;
    tick;
    hang_clr = 0;
    check("wd_clr", hang, 0);
    tick;
    check("wd_clr_hold", hang, 0);
    commit_valid = 1;
    tick;
    commit_valid = 0;
    for (int i = 0; i < 12; i++) tick;
    commit_valid = 1;
    tick;
    commit_valid = 0;
    for (int i = 0; i < 15; i++) tick;
    check("wd_commit", hang, 0);
    check("wd_commit_busy", busy, 0);
    commit_valid = 1;
`else
    commit_valid = 0;
    for (int i = 0; i < 40; i++) tick;
    check("nowd_hang", hang, 0);
    check("nowd_busy", busy, 0);
    commit_valid = 1;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
